// File: rtl/layernorm_row_scheduler.sv
// Row scheduler for a pool of layernorm_1d engines.
// Dispatches N_ROWS rows one start at a time and counts completions into one ap_ctrl_hs transaction.
module layernorm_row_scheduler #(
    parameter int unsigned N_ENG  = 4,
    parameter int unsigned N_ROWS = 8,
    parameter int unsigned ROW_W  = 8
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     ap_start,
    output logic                     ap_ready,
    output logic                     ap_done,
    output logic                     ap_idle,
    output logic [N_ENG-1:0]         eng_start,
    output logic [N_ENG*ROW_W-1:0]   eng_row_idx,
    input  logic [N_ENG-1:0]         eng_ready,
    input  logic [N_ENG-1:0]         eng_done,
    output logic [N_ENG-1:0]         cmpl_mask,
    output logic                     err
);

    localparam int unsigned PEND_W = (N_ENG > 1) ? $clog2(N_ENG) : 1;
    localparam int unsigned CNT_W  = ROW_W + 1;
    localparam int unsigned SUM_W  = ROW_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [N_ENG-1:0]       busy_q, busy_d;
    logic [ROW_W-1:0]       next_row_q, next_row_d;
    logic [CNT_W-1:0]       done_cnt_q, done_cnt_d;
    logic [PEND_W-1:0]      pend_q, pend_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [N_ENG-1:0]       eng_start_q, eng_start_d;
    logic [N_ENG*ROW_W-1:0] eng_row_idx_q, eng_row_idx_d;
    logic [N_ENG-1:0]       cmpl_mask_q, cmpl_mask_d;
    logic                   err_q, err_d;
    logic                   ap_ready_q, ap_ready_d;
    logic                   ap_done_q, ap_done_d;
    logic                   ap_idle_q, ap_idle_d;

    logic                   accept_c;
    logic [N_ENG-1:0]       accepting_c;
    logic [N_ENG-1:0]       valid_c;
    logic [SUM_W-1:0]       cnt_sum_c;
    logic                   free_found_c;
    logic [PEND_W-1:0]      free_idx_c;

    // Lowest-index engine not busy as of the current cycle.
    always_comb begin
        free_found_c = 1'b0;
        free_idx_c   = '0;
        for (int e = N_ENG - 1; e >= 0; e--) begin
            if (!busy_q[e]) begin
                free_found_c = 1'b1;
                free_idx_c   = PEND_W'(e);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        next_row_d    = next_row_q;
        done_cnt_d    = done_cnt_q;
        pend_d        = pend_q;
        pend_vld_d    = pend_vld_q;
        eng_start_d   = eng_start_q;
        eng_row_idx_d = eng_row_idx_q;
        err_d         = err_q;
        ap_ready_d    = 1'b0;
        ap_done_d     = 1'b0;

        accept_c    = pend_vld_q & eng_ready[pend_q];
        accepting_c = accept_c ? (N_ENG'(1) << pend_q) : '0;
        valid_c     = eng_done & (busy_q | accepting_c);
        cmpl_mask_d = valid_c;

        if (|(eng_done & ~(busy_q | accepting_c))) err_d = 1'b1;
        if (|(eng_ready & ~eng_start_q))           err_d = 1'b1;

        cnt_sum_c = SUM_W'(done_cnt_q);
        for (int e = 0; e < N_ENG; e++) begin
            cnt_sum_c = cnt_sum_c + SUM_W'(valid_c[e]);
        end
        if (cnt_sum_c > SUM_W'(N_ROWS)) begin
            err_d      = 1'b1;
            done_cnt_d = CNT_W'(N_ROWS);
        end else begin
            done_cnt_d = CNT_W'(cnt_sum_c);
        end

        // A completing engine is freed here but only becomes selectable next cycle.
        busy_d = (busy_q | accepting_c) & ~valid_c;

        if (accept_c) begin
            eng_start_d[pend_q] = 1'b0;
            pend_vld_d          = 1'b0;
            next_row_d          = next_row_q + ROW_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    state_d                  = S_DISPATCH;
                    next_row_d               = '0;
                    done_cnt_d               = '0;
                    busy_d                   = '0;
                    eng_start_d              = '0;
                    eng_start_d[0]           = 1'b1;
                    eng_row_idx_d[ROW_W-1:0] = '0;
                    pend_d                   = '0;
                    pend_vld_d               = 1'b1;
                end
            end
            S_DISPATCH: begin
                if (accept_c && (next_row_q == ROW_W'(N_ROWS - 1))) begin
                    ap_ready_d = 1'b1;
                    state_d    = (done_cnt_d == CNT_W'(N_ROWS)) ? S_DONE : S_DRAIN;
                end else if (!pend_vld_q && free_found_c) begin
                    eng_start_d[free_idx_c]                  = 1'b1;
                    eng_row_idx_d[free_idx_c*ROW_W +: ROW_W] = next_row_q;
                    pend_d                                   = free_idx_c;
                    pend_vld_d                               = 1'b1;
                end
            end
            S_DRAIN: begin
                if (done_cnt_d == CNT_W'(N_ROWS)) state_d = S_DONE;
            end
            S_DONE: begin
                ap_done_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        ap_idle_d = (state_d == S_IDLE);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q       <= S_IDLE;
            busy_q        <= '0;
            next_row_q    <= '0;
            done_cnt_q    <= '0;
            pend_q        <= '0;
            pend_vld_q    <= 1'b0;
            eng_start_q   <= '0;
            eng_row_idx_q <= '0;
            cmpl_mask_q   <= '0;
            err_q         <= 1'b0;
            ap_ready_q    <= 1'b0;
            ap_done_q     <= 1'b0;
            ap_idle_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            next_row_q    <= next_row_d;
            done_cnt_q    <= done_cnt_d;
            pend_q        <= pend_d;
            pend_vld_q    <= pend_vld_d;
            eng_start_q   <= eng_start_d;
            eng_row_idx_q <= eng_row_idx_d;
            cmpl_mask_q   <= cmpl_mask_d;
            err_q         <= err_d;
            ap_ready_q    <= ap_ready_d;
            ap_done_q     <= ap_done_d;
            ap_idle_q     <= ap_idle_d;
        end
    end

    assign ap_ready    = ap_ready_q;
    assign ap_done     = ap_done_q;
    assign ap_idle     = ap_idle_q;
    assign eng_start   = eng_start_q;
    assign eng_row_idx = eng_row_idx_q;
    assign cmpl_mask   = cmpl_mask_q;
    assign err         = err_q;

endmodule

// File: tb/tb_layernorm_row_scheduler.sv
// Directed bench for layernorm_row_scheduler: a small engine-pool model drives ready/done
// and logs which engine accepted which row; each scenario task checks against hand tables.
module tb_layernorm_row_scheduler;

    localparam int unsigned N_ENG  = 4;
    localparam int unsigned N_ROWS = 8;
    localparam int unsigned ROW_W  = 8;

    logic                   ap_clk;
    logic                   ap_rst_n;
    logic                   ap_start;
    logic                   ap_ready;
    logic                   ap_done;
    logic                   ap_idle;
    logic [N_ENG-1:0]       eng_start;
    logic [N_ENG*ROW_W-1:0] eng_row_idx;
    logic [N_ENG-1:0]       eng_ready;
    logic [N_ENG-1:0]       eng_done;
    logic [N_ENG-1:0]       cmpl_mask;
    logic                   err;

    layernorm_row_scheduler #(.N_ENG(N_ENG), .N_ROWS(N_ROWS), .ROW_W(ROW_W)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
        .eng_start(eng_start), .eng_row_idx(eng_row_idx),
        .eng_ready(eng_ready), .eng_done(eng_done),
        .cmpl_mask(cmpl_mask), .err(err)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    int tests = 0;
    int fails = 0;

    // Engine model configuration
    int               rdy_lat;
    int               done_lat;
    bit               zl;
    bit               hold0;
    logic [N_ENG-1:0] inj_done;
    int               age    [N_ENG];
    int               dtimer [N_ENG];

    // Observation log
    int acc_cnt;
    int acc_row [16];
    int acc_eng [16];
    int rdy_pulses, done_pulses, cmpl_bits, overlap, rdy_acc;

    task automatic model_clear();
        eng_ready = '0;
        eng_done  = '0;
        inj_done  = '0;
        rdy_lat   = 1;
        done_lat  = 10;
        zl        = 1'b0;
        hold0     = 1'b0;
        for (int e = 0; e < N_ENG; e++) begin
            age[e]    = 0;
            dtimer[e] = 0;
        end
        acc_cnt = 0; rdy_pulses = 0; done_pulses = 0;
        cmpl_bits = 0; overlap = 0; rdy_acc = -1;
        for (int k = 0; k < 16; k++) begin
            acc_row[k] = -1;
            acc_eng[k] = -1;
        end
    endtask

    // Advance one clock; account for what the edge accepted, then drive engine inputs.
    task automatic step();
        logic [N_ENG-1:0] sp, dr, nr, nd;
        int               ip [N_ENG];
        sp = eng_start;
        dr = eng_ready;
        for (int e = 0; e < N_ENG; e++) ip[e] = int'(eng_row_idx[e*ROW_W +: ROW_W]);
        @(posedge ap_clk);
        #1;
        for (int e = 0; e < N_ENG; e++) begin
            if (sp[e] && dr[e]) begin
                if (acc_cnt < 16) begin
                    acc_row[acc_cnt] = ip[e];
                    acc_eng[acc_cnt] = e;
                end
                acc_cnt++;
                if (!zl && done_lat > 0) dtimer[e] = done_lat;
            end
        end
        if (ap_ready) begin
            rdy_pulses++;
            rdy_acc = acc_cnt;
        end
        if (ap_done) done_pulses++;
        if (ap_ready && ap_done) overlap++;
        cmpl_bits += $countones(cmpl_mask);
        nr = '0;
        nd = inj_done;
        for (int e = 0; e < N_ENG; e++) begin
            age[e] = eng_start[e] ? age[e] + 1 : 0;
            if (eng_start[e] && age[e] > rdy_lat && !(e == 0 && hold0)) begin
                nr[e] = 1'b1;
                if (zl) nd[e] = 1'b1;
            end
            if (dtimer[e] > 0) begin
                dtimer[e]--;
                if (dtimer[e] == 0) nd[e] = 1'b1;
            end
        end
        eng_ready = nr;
        eng_done  = nd;
        inj_done  = '0;
    endtask

    task automatic start_txn();
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
    endtask

    task automatic run_to_done(input string name);
        int n  = 0;
        int d0 = done_pulses;
        while (done_pulses == d0 && n < 400) begin
            step();
            n++;
        end
        tests++;
        if (done_pulses == d0) begin
            fails++;
            $display("FAIL %s_timeout: no ap_done after %0d cycles", name, n);
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0; ap_start = 1'b0;
        model_clear();
        #12;
        tests++;
        if (ap_idle !== 1'b1 || eng_start !== '0 || ap_ready !== 1'b0 || ap_done !== 1'b0 ||
            err !== 1'b0 || cmpl_mask !== '0 || eng_row_idx !== '0) begin
            fails++;
            $display("FAIL reset_state: idle=%b start=%b rdy=%b done=%b err=%b cmpl=%b idx=%h required idle=1 rest 0",
                     ap_idle, eng_start, ap_ready, ap_done, err, cmpl_mask, eng_row_idx);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        step();
        tests++;
        if (ap_idle !== 1'b1 || eng_start !== '0) begin
            fails++;
            $display("FAIL reset_release: idle=%b start=%b required idle=1 start=0", ap_idle, eng_start);
        end
    endtask

    task automatic test_basic();
        model_clear();
        start_txn();
        tests++;
        if (eng_start !== 4'b0001 || eng_row_idx[ROW_W-1:0] !== 8'd0 || ap_idle !== 1'b0) begin
            fails++;
            $display("FAIL basic_first_start: start=%b idx0=%0d idle=%b required 0001/0/0",
                     eng_start, eng_row_idx[ROW_W-1:0], ap_idle);
        end
        run_to_done("basic");
        for (int k = 0; k < int'(N_ROWS); k++) begin
            tests++;
            if (acc_row[k] != k || acc_eng[k] != k % 4) begin
                fails++;
                $display("FAIL basic_map[%0d]: row=%0d eng=%0d required row=%0d eng=%0d",
                         k, acc_row[k], acc_eng[k], k, k % 4);
            end
        end
        tests++;
        if (rdy_pulses != 1 || rdy_acc != 8 || done_pulses != 1 || cmpl_bits != 8 ||
            err !== 1'b0 || overlap != 0 || ap_idle !== 1'b1) begin
            fails++;
            $display("FAIL basic_summary: ready=%0d@acc%0d done=%0d cmpl=%0d err=%b ovl=%0d idle=%b required 1@8 1 8 0 0 1",
                     rdy_pulses, rdy_acc, done_pulses, cmpl_bits, err, overlap, ap_idle);
        end
    endtask

    task automatic test_simultaneous_done();
        int n = 0;
        model_clear();
        done_lat = 0;
        start_txn();
        while (acc_cnt < 4 && n < 50) begin
            step();
            n++;
        end
        tests++;
        if (acc_cnt != 4 || eng_start !== '0) begin
            fails++;
            $display("FAIL sim_fill: accepts=%0d start=%b required 4/0000", acc_cnt, eng_start);
        end
        done_lat = 10;
        inj_done = 4'b1111;
        step();
        step();
        tests++;
        if (cmpl_mask !== 4'b1111 || cmpl_bits != 4 || eng_start !== '0) begin
            fails++;
            $display("FAIL sim_cmpl: cmpl=%b total=%0d start=%b required 1111/4/0000",
                     cmpl_mask, cmpl_bits, eng_start);
        end
        step();
        tests++;
        if (eng_start !== 4'b0001 || eng_row_idx[ROW_W-1:0] !== 8'd4) begin
            fails++;
            $display("FAIL sim_row4: start=%b idx0=%0d required 0001/4", eng_start, eng_row_idx[ROW_W-1:0]);
        end
        run_to_done("sim");
        tests++;
        if (cmpl_bits != 8 || err !== 1'b0 || acc_eng[5] != 1 || acc_eng[7] != 3) begin
            fails++;
            $display("FAIL sim_summary: cmpl=%0d err=%b eng5=%0d eng7=%0d required 8/0/1/3",
                     cmpl_bits, err, acc_eng[5], acc_eng[7]);
        end
    endtask

    task automatic test_back_pressure();
        model_clear();
        hold0 = 1'b1;
        start_txn();
        for (int c = 0; c < 5; c++) begin
            step();
            tests++;
            if (eng_start !== 4'b0001 || eng_row_idx[ROW_W-1:0] !== 8'd0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: start=%b idx0=%0d required 0001/0",
                         c, eng_start, eng_row_idx[ROW_W-1:0]);
            end
        end
        hold0 = 1'b0;
        run_to_done("bp");
        tests++;
        if (acc_eng[0] != 0 || acc_row[1] != 1 || acc_eng[1] != 1 || cmpl_bits != 8 || err !== 1'b0) begin
            fails++;
            $display("FAIL bp_after: e0=%0d row1=%0d e1=%0d cmpl=%0d err=%b required 0/1/1/8/0",
                     acc_eng[0], acc_row[1], acc_eng[1], cmpl_bits, err);
        end
    endtask

    task automatic test_zero_latency();
        int bad = 0;
        model_clear();
        rdy_lat = 0;
        zl      = 1'b1;
        start_txn();
        run_to_done("zl");
        for (int k = 0; k < int'(N_ROWS); k++) begin
            if (acc_row[k] != k || acc_eng[k] != 0) bad++;
        end
        tests++;
        if (bad != 0 || acc_cnt != 8) begin
            fails++;
            $display("FAIL zl_map: wrong=%0d accepts=%0d required 0/8", bad, acc_cnt);
        end
        tests++;
        if (cmpl_bits != 8 || done_pulses != 1 || rdy_pulses != 1 || overlap != 0 || err !== 1'b0) begin
            fails++;
            $display("FAIL zl_summary: cmpl=%0d done=%0d ready=%0d ovl=%0d err=%b required 8/1/1/0/0",
                     cmpl_bits, done_pulses, rdy_pulses, overlap, err);
        end
    endtask

    task automatic test_spurious_done();
        model_clear();
        start_txn();
        inj_done = 4'b0100;
        step();
        step();
        tests++;
        if (err !== 1'b1 || cmpl_mask !== '0 || cmpl_bits != 0) begin
            fails++;
            $display("FAIL spur_err: err=%b cmpl=%b total=%0d required 1/0000/0", err, cmpl_mask, cmpl_bits);
        end
        run_to_done("spur");
        tests++;
        if (err !== 1'b1 || cmpl_bits != 8 || done_pulses != 1 || acc_cnt != 8) begin
            fails++;
            $display("FAIL spur_summary: err=%b cmpl=%0d done=%0d accepts=%0d required 1/8/1/8",
                     err, cmpl_bits, done_pulses, acc_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        model_clear();
        start_txn();
        while (acc_cnt < 3 && n < 50) begin
            step();
            n++;
        end
        tests++;
        if (acc_cnt != 3 || ap_idle !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_pre: accepts=%0d idle=%b required 3/0", acc_cnt, ap_idle);
        end
        #2;
        ap_rst_n  = 1'b0;
        eng_ready = '0;
        eng_done  = '0;
        #1;
        tests++;
        if (eng_start !== '0 || ap_idle !== 1'b1 || err !== 1'b0 || cmpl_mask !== '0 ||
            eng_row_idx !== '0 || ap_ready !== 1'b0 || ap_done !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_clear: start=%b idle=%b err=%b cmpl=%b idx=%h rdy=%b done=%b required 0/1/0/0/0/0/0",
                     eng_start, ap_idle, err, cmpl_mask, eng_row_idx, ap_ready, ap_done);
        end
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        model_clear();
        start_txn();
        tests++;
        if (eng_start !== 4'b0001 || eng_row_idx[ROW_W-1:0] !== 8'd0) begin
            fails++;
            $display("FAIL rstmid_restart: start=%b idx0=%0d required 0001/0", eng_start, eng_row_idx[ROW_W-1:0]);
        end
        run_to_done("rstmid");
        tests++;
        if (acc_cnt != 8 || acc_row[0] != 0 || acc_eng[4] != 0 || cmpl_bits != 8 || err !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_summary: accepts=%0d row0=%0d eng4=%0d cmpl=%0d err=%b required 8/0/0/8/0",
                     acc_cnt, acc_row[0], acc_eng[4], cmpl_bits, err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_simultaneous_done();
        test_back_pressure();
        test_zero_latency();
        test_spurious_done();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/layernorm_row_scheduler.md
Name: layernorm_row_scheduler

Overview:
- Dispatches the rows of one token sequence across a pool of identical layernorm_1d engine instances, using each engine's ap_start/ap_ready/ap_done block protocol.
- Sits in myproject between the transpose stages and the engine pool. It presents a single ap_ctrl_hs-style interface upward.
- Reports each row completion and a sticky protocol-error flag.

Parameters:
- N_ENG, 4, number of layernorm_1d engines in the pool (1..8).
- N_ROWS, 8, rows per transaction (1..255).
- ROW_W, 8, width of a row index; must satisfy 2^ROW_W > N_ROWS.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  transaction request, level.
- ap_ready  out  1  one-cycle pulse when the last row has been accepted by an engine.
- ap_done  out  1  one-cycle pulse when all N_ROWS rows have completed.
- ap_idle  out  1  high while in IDLE.
- eng_start  out  N_ENG  per-engine ap_start.
- eng_row_idx  out  N_ENG*ROW_W  row index for each engine; slice e is valid while eng_start[e] is high.
- eng_ready  in  N_ENG  per-engine ap_ready.
- eng_done  in  N_ENG  per-engine ap_done, a one-cycle pulse.
- cmpl_mask  out  N_ENG  registered copy of the eng_done bits that were accepted as valid completions.
- err  out  1  sticky; set on a protocol violation.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - All outputs go to 0 except ap_idle, which goes to 1.
  - busy[], next_row, done_cnt, pend and err are cleared.
  - Reset mid-transaction drops all work; eng_start falls in the same cycle as reset.
- FSM states: IDLE, DISPATCH, DRAIN, DONE.
- IDLE:
  - If ap_start=1, go to DISPATCH and clear next_row, done_cnt and busy.
  - The first eng_start is asserted in the following cycle.
- DISPATCH:
  - When no start is pending and at least one engine has busy[e]=0, select the lowest-index free engine.
  - Register eng_start[e]=1 and eng_row_idx[e]=next_row, and set pend=e.
  - At most one start is outstanding at a time.
  - eng_start[pend] is held high until eng_ready[pend]=1 is sampled. In that cycle:
    - set busy[pend];
    - increment next_row;
    - drop eng_start next cycle.
  - A new dispatch may be issued in the cycle after the accept.
  - If the accepted row was N_ROWS-1, pulse ap_ready in the cycle after the accept and go to DRAIN.
- DRAIN:
  - When done_cnt reaches N_ROWS, go to DONE.
  - If the final completion happens in DISPATCH (the accept of the last row and its done in the same cycle), go directly to DONE.
- DONE:
  - Pulse ap_done for one cycle, then go to IDLE.
  - ap_start being high at that point starts a new transaction from IDLE on the next cycle.
- Completion rules:
  - Every cycle, valid = eng_done & (busy | accepting).
  - accepting is the one-hot of pend when eng_ready[pend]=1; this covers zero-latency engines.
  - done_cnt += popcount(valid).
  - cmpl_mask <= valid, registered with 1-cycle latency.
  - Engines in valid have busy cleared. A freed engine is eligible for dispatch in the next cycle, not the same cycle.
  - Multiple simultaneous dones are all counted in the same cycle.
- Error conditions (set err, never cleared except by reset):
  - eng_done[e]=1 with busy[e]=0 and e not accepting; the bit is ignored for counting.
  - eng_ready[e]=1 while eng_start[e]=0; ignored.
  - done_cnt would exceed N_ROWS; saturate done_cnt at N_ROWS.
- Other rules:
  - ap_start is ignored outside IDLE.
  - done_cnt width is ROW_W+1.
  - ap_idle=1 only in IDLE; ap_ready and ap_done are never high in the same cycle.
  - With N_ENG=1, rows are dispatched strictly serially.

Test Plan:
- Basic pass: N_ENG=4, N_ROWS=8; engines ready 1 cycle after start, done 10 cycles later.
  - Rows 0..3 go to engines 0..3.
  - Rows 4..7 go to engines 0..3 as they free.
  - ap_ready pulses once after row 7 is accepted; ap_done pulses once after 8 cmpl bits; err=0.
- Simultaneous done: engines 0..3 all pulse eng_done in the same cycle.
  - cmpl_mask=4'b1111 next cycle and done_cnt increases by 4.
  - Row 4 goes to engine 0 on the following cycle.
- Back-pressure: hold eng_ready[0]=0 for 5 cycles.
  - eng_start[0] stays high with row_idx 0 for those cycles; no other engine is started during them.
  - After the accept, row 1 goes to engine 1.
- Zero-latency engine: eng_ready and eng_done assert together for each start.
  - All 8 rows are dispatched to engine 0.
  - ap_done pulses with done_cnt=8 and err=0.
- Spurious done: eng_done[2] pulses while engine 2 is idle.
  - err=1 and stays 1; the completion count is unaffected.
  - The transaction still finishes after 8 real dones.
- Reset mid-operation: deassert ap_rst_n after 3 rows are accepted.
  - Outputs clear immediately; ap_idle=1.
  - A new ap_start restarts dispatch at row 0.
